// File: rtl/uart_defs.sv
// uart_defs: shared UART frame constants, state encodings and bit-period derivation
package uart_defs;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;
    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        START = S_START,
        DATA  = S_DATA,
        STOP  = S_STOP
    } state_t;
    function automatic int clks_per_bit(input int sys_clk, input int baud_rate);
        return sys_clk / baud_rate;
    endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter producing a one-cycle tick at each period end
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic bit_tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    logic [W-1:0] cnt;
    assign bit_tick = enable && cnt == W'(CLKS_PER_BIT - 1);
    // count while a frame is in flight, restarting at frame entry and each period end
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (clear || bit_tick)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with valid/ready byte handshake
module uart_tx
    import uart_defs::*;
#(
    parameter int SYS_CLK   = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx
);
    localparam int CLKS_PER_BIT = clks_per_bit(SYS_CLK, BAUD_RATE);
    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    state_t     state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_cnt, bit_n;
    logic       done_n, tx_n, tick, accept;
    assign tx_ready = state == IDLE;
    assign accept   = tx_ready && tx_valid;
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk(clk),
        .rst(rst),
        .enable(state != IDLE),
        .clear(accept),
        .bit_tick(tick)
    );
    // next-state, datapath and line level; tx is registered from the next state so it moves with the FSM
    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_cnt;
        done_n  = 1'b0;
        case (state)
            IDLE:  if (tx_valid) begin
                shift_n = tx_data;
                state_n = START;
            end
            START: if (tick) state_n = DATA;
            DATA:  if (tick) begin
                shift_n = shift >> 1;
                bit_n   = bit_cnt + 3'd1;
                if (bit_cnt == 3'(DATA_BITS - 1)) state_n = STOP;
            end
            STOP:  if (tick) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
    end
    // state registers; reset drops any partial frame and forces the line high at once
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx_done <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_cnt <= bit_n;
            tx_done <= done_n;
            tx      <= tx_n;
        end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench with a mid-bit sampling receive model
module tb_uart_tx;
    localparam int DCPB = 50000000 / 115200;
    localparam int FCPB = 16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic d_valid = 1'b0, f_valid = 1'b0;
    logic [7:0] d_data = '0, f_data = '0;
    logic d_ready, d_done, d_tx, f_ready, f_done, f_tx;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx u_d (
        .clk(clk), .rst(rst), .tx_valid(d_valid), .tx_data(d_data),
        .tx_ready(d_ready), .tx_done(d_done), .tx(d_tx)
    );
    uart_tx #(.SYS_CLK(16), .BAUD_RATE(1)) u_f (
        .clk(clk), .rst(rst), .tx_valid(f_valid), .tx_data(f_data),
        .tx_ready(f_ready), .tx_done(f_done), .tx(f_tx)
    );

    function automatic logic line(input bit s);
        return s ? f_tx : d_tx;
    endfunction
    function automatic logic done(input bit s);
        return s ? f_done : d_done;
    endfunction
    function automatic logic rdy(input bit s);
        return s ? f_ready : d_ready;
    endfunction

    task automatic send(input bit s, input logic [7:0] b);
        @(negedge clk);
        if (s) begin f_valid = 1'b1; f_data = b; end
        else begin d_valid = 1'b1; d_data = b; end
        @(posedge clk);
        #1;
        if (s) f_valid = 1'b0; else d_valid = 1'b0;
    endtask

    // expects the line to fall at the next negedge, then checks every cycle of the frame
    task automatic check_frame(input bit s, input int cpb, input logic [7:0] b, input string name);
        logic [9:0] fr;
        int n, bad_i;
        logic el, ed, got_l, got_d, got_r;
        fr = {1'b1, b, 1'b0};
        n = 0;
        do begin @(negedge clk); n++; end while (line(s) !== 1'b0 && n < 12 * cpb);
        tests++;
        if (line(s) !== 1'b0) begin
            fails++;
            $display("FAIL %s: no start bit, tx=%b required 0", name, line(s));
            return;
        end
        bad_i = -1;
        for (int i = 0; i <= 10 * cpb + 1; i++) begin
            if (i > 0) @(negedge clk);
            el = i < 10 * cpb ? fr[i / cpb] : 1'b1;
            ed = i == 10 * cpb;
            if (bad_i < 0 && (line(s) !== el || done(s) !== ed || (i <= 10 * cpb && rdy(s) !== ed))) begin
                bad_i = i; got_l = line(s); got_d = done(s); got_r = rdy(s);
            end
        end
        if (bad_i >= 0) begin
            fails++;
            $display("FAIL %s: cycle %0d tx/done/ready=%b%b%b required %b%b%b", name, bad_i,
                     got_l, got_d, got_r, bad_i < 10 * cpb ? fr[bad_i / cpb] : 1'b1,
                     bad_i == 10 * cpb, bad_i == 10 * cpb);
        end
    endtask

    // reference receiver: find the start edge, then sample each bit at its centre
    task automatic rx_frame(input bit s, input int cpb, output logic [7:0] b, output bit ok);
        int n;
        logic st, sp;
        b = 'x;
        n = 0;
        do begin @(negedge clk); n++; end while (line(s) !== 1'b0 && n < 12 * cpb);
        if (line(s) !== 1'b0) begin ok = 1'b0; return; end
        repeat (cpb / 2) @(negedge clk);
        st = line(s);
        for (int k = 0; k < 8; k++) begin
            repeat (cpb) @(negedge clk);
            b[k] = line(s);
        end
        repeat (cpb) @(negedge clk);
        sp = line(s);
        ok = st === 1'b0 && sp === 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({d_tx, d_ready, d_done, f_tx, f_ready, f_done} !== 6'b110110) begin
            fails++;
            $display("FAIL reset_values: got %b required 110110", {d_tx, d_ready, d_done, f_tx, f_ready, f_done});
        end
        rst = 1'b0;
        send(0, 8'h96);
        repeat (4 * DCPB + DCPB / 2) @(negedge clk);
        tests++;
        if (d_tx !== 1'b0) begin
            fails++;
            $display("FAIL pre_reset_bit3: tx=%b required 0", d_tx);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({d_tx, d_ready, d_done} !== 3'b110) begin
            fails++;
            $display("FAIL midframe_reset: tx/ready/done=%b required 110", {d_tx, d_ready, d_done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            int bad = 0;
            repeat (2 * DCPB) begin
                @(negedge clk);
                if (d_tx !== 1'b1 || d_done !== 1'b0 || d_ready !== 1'b1) bad++;
            end
            tests++;
            if (bad != 0) begin
                fails++;
                $display("FAIL post_reset_idle: %0d bad cycles required 0", bad);
            end
        end
        send(0, 8'hC3);
        check_frame(0, DCPB, 8'hC3, "post_reset_frame");
    endtask

    task automatic test_single();
        send(0, 8'h55);
        tests++;
        if ({d_tx, d_ready} !== 2'b00) begin
            fails++;
            $display("FAIL accept_edge: tx/ready=%b required 00", {d_tx, d_ready});
        end
        check_frame(0, DCPB, 8'h55, "frame_55");
    endtask

    task automatic test_data_hold();
        send(0, 8'hA5);
        d_data = 8'hFF;
        check_frame(0, DCPB, 8'hA5, "data_hold_A5");
    endtask

    task automatic test_busy();
        int bad = 0;
        send(0, 8'h0F);
        fork
            check_frame(0, DCPB, 8'h0F, "busy_frame_0F");
            begin
                repeat (2 * DCPB) @(negedge clk);
                d_valid = 1'b1;
                d_data  = 8'h3C;
                @(negedge clk);
                d_valid = 1'b0;
            end
        join
        repeat (3 * DCPB) begin
            @(negedge clk);
            if (d_tx !== 1'b1 || d_done !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL busy_not_queued: %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic rec_l[0:340];
        logic rec_d[0:340];
        logic [9:0] f0, f1;
        logic el;
        int bad, first_bad, ones, d0, d1;
        f0 = {1'b1, 8'h00, 1'b0};
        f1 = {1'b1, 8'hFF, 1'b0};
        @(negedge clk);
        f_valid = 1'b1;
        f_data  = 8'h00;
        @(posedge clk);
        #1;
        f_data = 8'hFF;
        for (int i = 0; i <= 340; i++) begin
            @(negedge clk);
            rec_l[i] = f_tx;
            rec_d[i] = f_done;
            if (i == 161) f_valid = 1'b0;
        end
        bad = 0;
        first_bad = -1;
        for (int i = 0; i <= 340; i++) begin
            el = i < 160 ? f0[i / FCPB] : (i >= 161 && i < 321) ? f1[(i - 161) / FCPB] : 1'b1;
            if (rec_l[i] !== el) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL b2b_line: %0d wrong cycles (first %0d) required 0", bad, first_bad);
        end
        ones = 0;
        for (int i = 160; i >= 0 && rec_l[i] === 1'b1; i--) ones++;
        tests++;
        if (ones != 17) begin
            fails++;
            $display("FAIL b2b_stop_len: %0d cycles required 17", ones);
        end
        d0 = -1;
        d1 = -1;
        bad = 0;
        for (int i = 0; i <= 340; i++)
            if (rec_d[i] === 1'b1) begin
                bad++;
                if (d0 < 0) d0 = i; else if (d1 < 0) d1 = i;
            end
        tests++;
        if (bad != 2 || d1 - d0 != 161) begin
            fails++;
            $display("FAIL b2b_done: %0d pulses spacing %0d required 2 pulses spacing 161", bad, d1 - d0);
        end
    endtask

    task automatic test_random();
        logic [7:0] b, got;
        bit ok;
        int n;
        for (int t = 0; t < 256; t++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(1, b);
            rx_frame(1, FCPB, got, ok);
            tests++;
            if (!ok || got !== b) begin
                fails++;
                $display("FAIL random_rx[%0d]: got %h framing_ok=%0d required %h", t, got, ok, b);
            end
            n = 0;
            while (f_ready !== 1'b1 && n < 4 * FCPB) begin @(negedge clk); n++; end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_data_hold();
        test_busy();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one byte per handshake into an 8N1 frame (start bit 0, eight data bits LSB first, stop bit 1) on a single serial line. The bit period is derived from the system clock by an internal integer divider. It is the transmit-side counterpart of the UART receive path and shares its `SYS_CLK`/`BAUD_RATE` parameterisation. It sits between a byte-producing client (host FSM, FIFO) and the `tx` pad.

## Interface
- `SYS_CLK`, default 50000000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `CLKS_PER_BIT` (localparam): `SYS_CLK/BAUD_RATE`, integer truncation (434 at defaults). Elaboration must fail if the value is < 2.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `tx_valid`, input, 1: client offers `tx_data`.
- `tx_data`, input, 8: byte to send; sampled only at acceptance.
- `tx_ready`, output, 1: high when the block can accept a byte (IDLE state).
- `tx_done`, output, 1: one-cycle pulse after the stop bit completes.
- `tx`, output, 1: serial line, registered. Idles high.

## Operation
- Reset values:
  - `tx=1`, `tx_ready=1`, `tx_done=0`.
  - state IDLE, bit counter 0, baud counter 0, shift register 0.
- States:
  - IDLE: `tx=1`, `tx_ready=1`. If `tx_valid` is high on a clock edge, load `tx_data` into the shift register and go to START.
  - START: `tx=0` for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx=shift[0]`. At each bit-period end, shift right and increment the bit counter (3 bits). After bit index 7 completes, go to STOP.
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles, then go to IDLE and pulse `tx_done`.
- Handshake: a transfer occurs on a clock edge where `tx_valid && tx_ready`.
  - `tx_valid` outside IDLE is ignored. Nothing is queued.
  - `tx_data` changes after acceptance have no effect on the frame in flight.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`.
  - Cleared on entry to START and at each bit-period end.
  - Bit-period end = counter equals `CLKS_PER_BIT-1`.
  - Free-runs only while not in IDLE.
- Reset mid-frame: `tx` returns high immediately (asynchronous). The partial frame is abandoned and `tx_done` is not pulsed. After release, the block is in IDLE.

## Timing
- Acceptance at edge N: `tx` falls at edge N+1. All state registers and `tx` update on the same edge.
- Each bit lasts exactly `CLKS_PER_BIT` cycles. Frame from start-bit fall to end of stop bit is `10*CLKS_PER_BIT` cycles.
- On the edge that ends the stop bit: state goes to IDLE and `tx_ready` and `tx_done` both go high. `tx_done` is high for exactly one cycle.
- Back-to-back: with `tx_valid` held high, the next byte is accepted in that first IDLE cycle. The next start bit begins one cycle later, so the inter-frame gap is one clock of extra idle high (stop bit = `CLKS_PER_BIT+1` cycles).
- Baud-rate error from truncation is accepted as is. No fractional correction.

## Structure
- Shared package/include `uart_defs`:
  - State encodings IDLE/START/DATA/STOP as 2-bit localparams.
  - Frame constants: `DATA_BITS=8`, `STOP_BITS=1`.
  - The `CLKS_PER_BIT` derivation, reused by the receive side.
- One sub-module, `uart_baud_gen`: bit-period counter with `enable`/`clear` inputs and a one-cycle `bit_tick` output. The FSM, shift register and bit counter stay in `uart_tx`.

## Test plan
- Reset values: assert `rst` mid-frame (during DATA bit 3) → `tx=1` within the same cycle, `tx_ready=1`, `tx_done=0`. The next accepted byte transmits a full, clean frame.
- Single frame, defaults: send 0x55 → `tx` holds levels 0,1,0,1,0,1,0,1,0,1 (start, LSB..MSB, stop), each exactly 434 clocks. `tx_done` pulses once, 4340 clocks after the start-bit fall.
- Data hold: send 0xA5 and change `tx_data` to 0xFF one cycle after acceptance → line carries 0xA5 (bits 1,0,1,0,0,1,0,1).
- Busy rejection: pulse `tx_valid` with 0x3C during a frame of 0x0F → 0x3C is never transmitted and `tx_ready` stays 0 until the stop bit ends.
- Back-to-back: `SYS_CLK=16`, `BAUD_RATE=1` (16 clocks/bit), hold `tx_valid` with 0x00 then 0xFF → two frames. The first stop bit lasts 17 cycles and there are two `tx_done` pulses, 161 cycles apart.
- Checker: a reference UART receive model sampling at mid-bit decodes 256 random bytes with zero errors.
